// File: rtl/lsu.sv
// Load/store unit: single outstanding byte/half/word access on a valid/ready RAM port,
// with store lane alignment, load extension and misalignment detection.
module lsu #(
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    input  logic                 req_store_i,
    input  logic [1:0]           req_size_i,
    input  logic                 req_unsigned_i,
    output logic                 resp_valid_o,
    output logic [31:0]          resp_data_o,
    output logic                 resp_err_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wr_data_o,
    output logic [3:0]           mem_wr_en_o,
    input  logic [31:0]          mem_rd_data_i,
    input  logic                 mem_rd_valid_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRd, StResp} state_e;

    state_e               state_q, state_d;
    logic                 accept, misaligned, mem_hs;
    logic [1:0]           lane_q, size_q;
    logic                 store_q, unsigned_q;
    logic                 mem_valid_q, resp_err_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic [31:0]          mem_wr_data_q, resp_data_q;
    logic [3:0]           mem_wr_en_q;
    logic [3:0]           wr_mask;
    logic [31:0]          wr_data, rd_shift, load_ext;

    // Address bits above the RAM size wrap and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr_i[31:AddrWidth+2];

    assign accept = req_valid_i && req_ready_o;
    assign mem_hs = mem_valid_q && mem_ready_i;

    always_comb begin
        case (req_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = (req_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        wr_mask = 4'h0;
        wr_data = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                wr_mask = 4'b0001 << req_addr_i[1:0];
                wr_data = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                wr_mask = 4'b0011 << req_addr_i[1:0];
                wr_data = {2{req_wdata_i[15:0]}};
            end
            default: wr_mask = 4'hF;
        endcase
        if (!req_store_i) begin
            wr_mask = 4'h0;
        end
    end

    assign rd_shift = mem_rd_data_i >> {lane_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_ext = unsigned_q ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    load_ext = unsigned_q ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = misaligned ? StResp : StReq;
            StReq:    if (mem_hs) state_d = store_q ? StResp : StWaitRd;
            StWaitRd: if (mem_rd_valid_i) state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        resp_valid_o = (state_q == StResp);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q        <= 2'b00;
            size_q        <= 2'b00;
            store_q       <= 1'b0;
            unsigned_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= 32'h0;
            mem_wr_en_q   <= 4'h0;
            resp_data_q   <= 32'h0;
            resp_err_q    <= 1'b0;
        end else if (accept) begin
            lane_q      <= req_addr_i[1:0];
            size_q      <= req_size_i;
            store_q     <= req_store_i;
            unsigned_q  <= req_unsigned_i;
            resp_data_q <= 32'h0;
            resp_err_q  <= misaligned;
            if (!misaligned) begin
                mem_valid_q   <= 1'b1;
                mem_addr_q    <= req_addr_i[AddrWidth+1:2];
                mem_wr_data_q <= wr_data;
                mem_wr_en_q   <= wr_mask;
            end
        end else if (state_q == StReq && mem_hs) begin
            mem_valid_q <= 1'b0;
            mem_wr_en_q <= 4'h0;
        end else if (state_q == StWaitRd && mem_rd_valid_i) begin
            resp_data_q <= load_ext;
        end else if (state_q == StResp) begin
            resp_data_q <= 32'h0;
            resp_err_q  <= 1'b0;
        end
    end

    assign mem_valid_o   = mem_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu against a small byte-masked RAM model with 1-cycle read latency.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        req_store_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b1;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wr_data_o;
    logic [3:0]  mem_wr_en_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_rd_valid_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [256];
    logic        rd_valid_q = 1'b0;
    logic [31:0] rd_data_q = 32'h0;
    logic        rd_block = 1'b0;
    logic        rd_force = 1'b0;
    logic [31:0] rd_force_data = 32'h0;
    int          wr_count = 0;

    lsu #(.AddrWidth(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_store_i    (req_store_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_rd_valid_i (mem_rd_valid_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        rd_valid_q <= 1'b0;
        if (mem_valid_o && mem_ready_i) begin
            if (mem_wr_en_o != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wr_en_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wr_data_o[8*b +: 8];
                end
                wr_count <= wr_count + 1;
            end else if (!rd_block) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= ram[mem_addr_o];
            end
        end
    end

    assign mem_rd_valid_i = rd_valid_q | rd_force;
    assign mem_rd_data_i  = rd_force ? rd_force_data : rd_data_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; lat is -1 on timeout.
    task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic saw_mv, output logic [7:0] maddr,
                          output logic [3:0] mmask, output logic [31:0] mdata);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_store_i = st;
        req_size_i = sz;
        req_unsigned_i = uns;
        req_addr_i = addr;
        req_wdata_i = wd;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 1;
        saw_mv = 1'b0;
        rdata = 32'h0;
        err = 1'b0;
        maddr = 8'h0;
        mmask = 4'h0;
        mdata = 32'h0;
        while (!resp_valid_o && lat < 20) begin
            if (mem_valid_o && !saw_mv) begin
                saw_mv = 1'b1;
                maddr = mem_addr_o;
                mmask = mem_wr_en_o;
                mdata = mem_wr_data_o;
            end
            @(negedge clk_i);
            lat++;
        end
        if (resp_valid_o) begin
            rdata = resp_data_o;
            err = resp_err_o;
        end else begin
            lat = -1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'h0, req_ready_o}, 32'd1);
        check({tag, "_mvalid"}, {31'h0, mem_valid_o}, 32'd0);
        check({tag, "_wren"}, {28'h0, mem_wr_en_o}, 32'd0);
        check({tag, "_maddr"}, {24'h0, mem_addr_o}, 32'd0);
        check({tag, "_wdata"}, mem_wr_data_o, 32'd0);
        check({tag, "_rvalid"}, {31'h0, resp_valid_o}, 32'd0);
        check({tag, "_rdata"}, resp_data_o, 32'd0);
        check({tag, "_rerr"}, {31'h0, resp_err_o}, 32'd0);
    endtask

    logic [31:0] rdata, mdata;
    logic        err, saw_mv;
    int          lat;
    logic [7:0]  maddr;
    logic [3:0]  mmask;

    typedef struct {
        string       tag;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic        exp_mv;
        logic [7:0]  exp_maddr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        //        tag          st  sz   uns  addr   wdata         data          err lat mv maddr mask mdata
        vecs.push_back('{"sw_10",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 8'd4, 4'hF, 32'hDEADBEEF});
        vecs.push_back('{"lw_10",   0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 1, 8'd4, 4'h0, 32'h0});
        vecs.push_back('{"sw0_10",  1, 2'd2, 0, 32'h10, 32'h0,        32'h0,        0, 2, 1, 8'd4, 4'hF, 32'h0});
        vecs.push_back('{"sb_13",   1, 2'd0, 0, 32'h13, 32'h123456A5, 32'h0,        0, 2, 1, 8'd4, 4'h8, 32'hA5A5A5A5});
        vecs.push_back('{"lb_13",   0, 2'd0, 0, 32'h13, 32'h0,        32'hFFFFFFA5, 0, 3, 1, 8'd4, 4'h0, 32'h0});
        vecs.push_back('{"lbu_13",  0, 2'd0, 1, 32'h13, 32'h0,        32'h000000A5, 0, 3, 1, 8'd4, 4'h0, 32'h0});
        vecs.push_back('{"lw_10b",  0, 2'd2, 0, 32'h10, 32'h0,        32'hA5000000, 0, 3, 1, 8'd4, 4'h0, 32'h0});
        vecs.push_back('{"sh_22",   1, 2'd1, 0, 32'h22, 32'h00008001, 32'h0,        0, 2, 1, 8'd8, 4'hC, 32'h80018001});
        vecs.push_back('{"lh_22",   0, 2'd1, 0, 32'h22, 32'h0,        32'hFFFF8001, 0, 3, 1, 8'd8, 4'h0, 32'h0});
        vecs.push_back('{"lhu_22",  0, 2'd1, 1, 32'h22, 32'h0,        32'h00008001, 0, 3, 1, 8'd8, 4'h0, 32'h0});
        vecs.push_back('{"lw_11",   0, 2'd2, 0, 32'h11, 32'h0,        32'h0,        1, 1, 0, 8'd0, 4'h0, 32'h0});
        vecs.push_back('{"sh_21",   1, 2'd1, 0, 32'h21, 32'h1111,     32'h0,        1, 1, 0, 8'd0, 4'h0, 32'h0});
        vecs.push_back('{"size3",   0, 2'd3, 0, 32'h20, 32'h0,        32'h0,        1, 1, 0, 8'd0, 4'h0, 32'h0});
        // Address bits above the RAM wrap: 0x410 lands on word 4.
        vecs.push_back('{"lw_wrap", 0, 2'd2, 0, 32'h410, 32'h0,       32'hA5000000, 0, 3, 1, 8'd4, 4'h0, 32'h0});

        foreach (vecs[i]) begin
            access(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   rdata, err, lat, saw_mv, maddr, mmask, mdata);
            check({vecs[i].tag, "_data"}, rdata, vecs[i].exp_data);
            check({vecs[i].tag, "_err"}, {31'h0, err}, {31'h0, vecs[i].exp_err});
            check({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].tag, "_memvalid"}, {31'h0, saw_mv}, {31'h0, vecs[i].exp_mv});
            if (vecs[i].exp_mv) begin
                check({vecs[i].tag, "_maddr"}, {24'h0, maddr}, {24'h0, vecs[i].exp_maddr});
                check({vecs[i].tag, "_mask"}, {28'h0, mmask}, {28'h0, vecs[i].exp_mask});
                if (vecs[i].st) check({vecs[i].tag, "_mdata"}, mdata, vecs[i].exp_mdata);
            end
        end

        // Backpressure: mem_ready low for cycles 1..5 of a word store.
        begin
            int   w0;
            int   resp_cnt;
            logic stable;
            logic busy;
            w0 = wr_count;
            stable = 1'b1;
            busy = 1'b0;
            resp_cnt = 0;
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            req_valid_i = 1'b1;
            req_store_i = 1'b1;
            req_size_i = 2'd2;
            req_unsigned_i = 1'b0;
            req_addr_i = 32'h30;
            req_wdata_i = 32'h12345678;
            @(negedge clk_i);
            req_valid_i = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                if (!(mem_valid_o && mem_addr_o == 8'd12 && mem_wr_en_o == 4'hF &&
                      mem_wr_data_o == 32'h12345678)) stable = 1'b0;
                if (req_ready_o) busy = 1'b1;
                if (c == 5) mem_ready_i = 1'b1;
                @(negedge clk_i);
            end
            for (int c = 0; c < 6; c++) begin
                if (resp_valid_o) resp_cnt++;
                @(negedge clk_i);
            end
            check("bp_stable", {31'h0, stable}, 32'd1);
            check("bp_ready_low", {31'h0, busy}, 32'd0);
            check("bp_writes", 32'(wr_count - w0), 32'd1);
            check("bp_resp_pulses", 32'(resp_cnt), 32'd1);
        end
        access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rdata, err, lat, saw_mv, maddr, mmask, mdata);
        check("bp_readback", rdata, 32'h12345678);

        // Reset while the load sits in WAIT_RD.
        begin
            logic stray;
            stray = 1'b0;
            rd_block = 1'b1;
            @(negedge clk_i);
            req_valid_i = 1'b1;
            req_store_i = 1'b0;
            req_size_i = 2'd2;
            req_addr_i = 32'h10;
            @(negedge clk_i);
            req_valid_i = 1'b0;
            @(negedge clk_i);
            check("rst_in_waitrd_busy", {31'h0, req_ready_o}, 32'd0);
            #1 rst_ni = 1'b0;
            #1;
            check_reset_outputs("rst_mid");
            rd_block = 1'b0;
            @(negedge clk_i);
            rst_ni = 1'b1;
            @(negedge clk_i);
            rd_force = 1'b1;
            rd_force_data = 32'hFFFFFFFF;
            @(negedge clk_i);
            rd_force = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (resp_valid_o) stray = 1'b1;
                @(negedge clk_i);
            end
            check("rst_stray_resp", {31'h0, stray}, 32'd0);
        end
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rdata, err, lat, saw_mv, maddr, mmask, mdata);
        check("post_rst_data", rdata, 32'hA5000000);
        check("post_rst_lat", 32'(lat), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that initiates transactions on the single-port synchronous RAM interface (valid/ready request, write-mask, rd_valid response) from the core side. It accepts one byte, half-word or word access at a time, aligns store data and generates the byte write mask. It sign- or zero-extends returned load data and flags misaligned accesses without touching memory. It sits between the core's execute stage and the data RAM.

## Interface
- AddrWidth, 8: word-address width driven to the RAM; byte address bits [AddrWidth+1:2] are used.
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  LSU idle and able to accept a request.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data, right-justified.
- req_store_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- req_unsigned_i  input  1  loads zero-extend when 1, otherwise sign-extend.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_data_o  output  32  extended load data; 0 for stores and errors.
- resp_err_o  output  1  misaligned/illegal access, valid with resp_valid_o.
- mem_valid_o  output  1  RAM request valid.
- mem_ready_i  input  1  RAM ready.
- mem_addr_o  output  AddrWidth  word address.
- mem_wr_data_o  output  32  lane-replicated store data.
- mem_wr_en_o  output  4  byte write mask; 0 = read.
- mem_rd_data_i  input  32  RAM read word.
- mem_rd_valid_i  input  1  RAM read data valid.

## Operation
- FSM states: IDLE, REQ, WAIT_RD, RESP.
- req_ready_o = (state == IDLE). Acceptance occurs on req_valid_i && req_ready_o. At acceptance, addr, size, store, unsigned and wdata are registered.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 3. A misaligned request goes IDLE->RESP and issues no mem_valid_o. The response is resp_err_o=1 with resp_data_o=0.
- Aligned request: IDLE->REQ. mem_valid_o is held high with stable addr, data and mask until mem_valid_o && mem_ready_i.
  - On that handshake, a store goes to RESP and a load goes to WAIT_RD.
- WAIT_RD->RESP on mem_rd_valid_i. mem_rd_data_i is captured, shifted right by 8*addr[1:0], then sign- or zero-extended to 32 bits by size.
- RESP: resp_valid_o=1 for exactly one cycle, then the FSM returns to IDLE.
- Lane rules, where lane = addr[1:0]:
  - Byte: mask = 4'b0001 << lane; data = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011 << lane; data = {2{wdata[15:0]}}.
  - Word: mask = 4'hF; data = wdata.
  - Loads: mask = 0.
- mem_addr_o = addr[AddrWidth+1:2]. Higher address bits are ignored (address wraps modulo RAM size).
- mem_rd_valid_i is ignored outside WAIT_RD.

## Timing
- Reset values: state IDLE, req_ready_o=1, mem_valid_o=0, mem_wr_en_o=0, mem_addr_o=0, mem_wr_data_o=0, resp_valid_o=0, resp_data_o=0, resp_err_o=0. No request is captured while rst_ni=0.
- Reset mid-operation forces IDLE immediately (asynchronously) and drops mem_valid_o. A subsequent stray mem_rd_valid_i is ignored.
- With mem_ready_i=1 and 1-cycle RAM read latency, taking acceptance as cycle 0:
  - Store: mem handshake in cycle 1, resp_valid_o in cycle 2.
  - Load: mem handshake in cycle 1, mem_rd_valid_i in cycle 2, resp_valid_o in cycle 3.
  - Misaligned: resp_valid_o in cycle 1.
- Each cycle of mem_ready_i=0 in REQ adds one cycle. Each extra cycle of RAM read latency adds one cycle.
- Throughput: one access in flight. The next request is accepted in the cycle after resp_valid_o (IDLE).
- resp_data_o, resp_err_o and all mem_* outputs are registered. req_ready_o is decoded from the state register.

## Test plan
- Word store/load with RAM ready=1: store 0xDEADBEEF to 0x10, then load from 0x10.
  - Store: mem_addr_o=4, mask=F.
  - Load: resp_data_o=0xDEADBEEF, arriving 3 cycles after acceptance.
- Byte store 0xA5 to 0x13 (mask=4'b1000, data 0xA5A5A5A5) after memory holds 0x00000000.
  - lb from 0x13 returns 0xFFFFFFA5.
  - lbu from 0x13 returns 0x000000A5.
  - lw from 0x10 returns 0xA5000000.
- Half store 0x8001 to 0x22 (mask=4'b1100).
  - lh from 0x22 returns 0xFFFF8001.
  - lhu from 0x22 returns 0x00008001.
- Misaligned cases: lw at 0x11, sh at 0x21 and size=3.
  - Each yields resp_err_o=1 and resp_data_o=0 in cycle 1.
  - mem_valid_o never asserts.
- Backpressure: hold mem_ready_i=0 for 5 cycles during a store.
  - mem_valid_o, addr, data and mask stay stable for those 5 cycles.
  - req_ready_o=0 throughout.
  - Exactly one write occurs, and resp_valid_o pulses once.
- Reset mid-load: assert rst_ni=0 in WAIT_RD.
  - All outputs take their reset values immediately.
  - A mem_rd_valid_i pulse after reset produces no resp_valid_o.
  - The next load completes normally.
